rr_mux_4x1: RTL and testbench

Sequential 4-to-1 stream merger. It is the collecting end of the 1-to-4 routing path: four independent valid/ready producer channels are arbitrated round-robin onto one registered valid/ready output. The index of the winning channel travels with each beat, so a downstream 1-to-4 router can steer the beat back by that index.

---
 rtl/rr_mux_4x1_if.sv | 35 +++
 rtl/rr_mux_4x1.sv | 84 ++++++++
 tb/tb_rr_mux_4x1.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rr_mux_4x1_if.sv
// Stream bundle for the 4-to-1 round-robin merger: four producer channels in,
// one registered beat (with its source index) out.
interface rr_mux_4x1_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_sel;
  logic                out_ready;

  // Merger side: consumes the four channels, produces the merged stream.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  // Environment side: producers and the downstream consumer.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );
endinterface

// File: rtl/rr_mux_4x1.sv
// Round-robin 4-to-1 stream merger with a one-beat registered output stage.
// The winning channel index is carried alongside each beat on out_sel.
module rr_mux_4x1 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_mux_4x1_if.slave   io_bus
);

  logic [1:0]        r_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_sel;

  logic              w_load_en;
  logic              w_grant_vld;
  logic              w_push;
  logic [1:0]        w_grant;
  logic [1:0]        w_idx;
  logic [DATA_W-1:0] w_grant_data;
  logic [3:0]        w_in_ready;

  // Search in_valid from ptr upward (mod 4); the lowest offset wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = r_ptr;
    w_idx       = '0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (io_bus.in_valid[w_idx]) begin
        w_grant     = w_idx;
        w_grant_vld = 1'b1;
      end
    end
  end

  // Select the granted channel's data slice.
  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_grant == 2'(k)) begin
        w_grant_data = io_bus.in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Ready goes only to the winner; it is combinational in out_ready so a pop
  // and a push can share an edge. Forced low while reset is asserted.
  always_comb begin
    w_load_en  = !r_out_valid | io_bus.out_ready;
    w_push     = rst_n & w_load_en & w_grant_vld;
    w_in_ready = '0;
    if (w_push) begin
      w_in_ready[w_grant] = 1'b1;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load_en) begin
      if (w_grant_vld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_sel   <= w_grant;
        r_ptr       <= w_grant + 2'd1;
      end else begin
        // Nothing to load: drop valid, keep data/sel/ptr as they were.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// Directed bench for rr_mux_4x1: expected beats are queued when a grant is
// expected and checked against the output register until consumed.
module tb_rr_mux_4x1;
  localparam int unsigned DATA_W = 8;

  logic clk;
  logic rst_n;

  rr_mux_4x1_if #(.DATA_W(DATA_W)) bus ();

  rr_mux_4x1 #(.DATA_W(DATA_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [DATA_W-1:0] ch_data [4];
  logic [9:0]        sb_q [$];   // {sel[1:0], data[7:0]}
  logic              exp_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check, update the scoreboard, take the edge.
  task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] exp_ready,
                      input string tag);
    logic [1:0] gi;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    bus.in_data   = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_vld));
    if (exp_vld) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'(1), 32'(0));
      end else begin
        chk({tag, ".out_sel"}, 32'(bus.out_sel), 32'(sb_q[0][9:8]));
        chk({tag, ".out_data"}, 32'(bus.out_data), 32'(sb_q[0][7:0]));
        if (rdy) void'(sb_q.pop_front());
      end
    end
    if (!exp_vld || rdy) begin
      if (exp_ready != 4'b0000) begin
        gi = 2'd0;
        case (exp_ready)
          4'b0010: gi = 2'd1;
          4'b0100: gi = 2'd2;
          4'b1000: gi = 2'd3;
          default: gi = 2'd0;
        endcase
        sb_q.push_back({gi, ch_data[gi]});
        exp_vld = 1'b1;
      end else begin
        exp_vld = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    exp_vld       = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) ch_data[i] = '0;

    // Reset state: outputs cleared, no ready even with requests pending.
    #2;
    chk("rst.out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst.out_data", 32'(bus.out_data), 32'(0));
    chk("rst.out_sel", 32'(bus.out_sel), 32'(0));
    chk("rst.in_ready", 32'(bus.in_ready), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat on ch2.
    ch_data[2] = 8'hA5;
    step(4'b0100, 1'b1, 4'b0100, "single");
    chk("single.ptr", 32'(dut.r_ptr), 32'(3));
    step(4'b0000, 1'b1, 4'b0000, "single_drain");

    // Idle gaps: from ptr 3, ch0 then nothing then ch3.
    ch_data[0] = 8'h01;
    ch_data[3] = 8'h08;
    step(4'b0001, 1'b1, 4'b0001, "gap0");
    step(4'b0000, 1'b1, 4'b0000, "gap1");
    step(4'b1000, 1'b1, 4'b1000, "gap2");
    step(4'b0000, 1'b1, 4'b0000, "gap_drain");

    // Full contention: strict rotation, no bubbles.
    for (int i = 0; i < 4; i++) ch_data[i] = 8'h10 + 8'(i);
    for (int n = 0; n < 8; n++) begin
      step(4'b1111, 1'b1, 4'b0001 << (n % 4), "rotate");
    end

    // Async reset in the middle of traffic.
    step(4'b1111, 1'b1, 4'b0001, "mid");
    step(4'b1111, 1'b1, 4'b0010, "mid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(bus.out_valid), 32'(0));
    chk("arst.out_data", 32'(bus.out_data), 32'(0));
    chk("arst.in_ready", 32'(bus.in_ready), 32'(0));
    sb_q.delete();
    exp_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst.ptr", 32'(dut.r_ptr), 32'(0));

    // First grant after reset is ch0; ch1 then loads 3C and gets stalled.
    ch_data[1] = 8'h3C;
    step(4'b1111, 1'b1, 4'b0001, "post_rst");
    step(4'b1111, 1'b1, 4'b0010, "bp_load");
    for (int n = 0; n < 5; n++) begin
      step(4'b1111, 1'b0, 4'b0000, "bp_hold");
    end
    step(4'b1111, 1'b1, 4'b0100, "bp_rel0");
    step(4'b1111, 1'b1, 4'b1000, "bp_rel1");
    step(4'b0000, 1'b1, 4'b0000, "bp_drain");

    // Wrap search: move ptr to 2 via ch1, then ch1 alone wins from ptr 2.
    ch_data[1] = 8'h55;
    step(4'b0010, 1'b1, 4'b0010, "wrap_prep");
    chk("wrap_prep.ptr", 32'(dut.r_ptr), 32'(2));
    ch_data[1] = 8'h77;
    step(4'b0010, 1'b1, 4'b0010, "wrap");
    chk("wrap.ptr", 32'(dut.r_ptr), 32'(2));
    step(4'b0000, 1'b1, 4'b0000, "wrap_drain");
    step(4'b0000, 1'b1, 4'b0000, "idle");
    chk("sb_left", 32'(sb_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
